// File: rtl/ps2_kbd_pkg.sv
// Shared Set-2 scan byte constants, parser states and the queued event format
// for the PS/2 key event queue.
package ps2_kbd_pkg;

    localparam logic [7:0] KB_EXT      = 8'hE0;
    localparam logic [7:0] KB_BRK      = 8'hF0;
    localparam logic [7:0] KB_PAUSE    = 8'hE1;
    localparam logic [7:0] KB_BAT_OK   = 8'hAA;
    localparam logic [7:0] KB_BAT_FAIL = 8'hFC;
    localparam logic [7:0] KB_ACK      = 8'hFA;
    localparam logic [7:0] KB_ECHO     = 8'hEE;
    localparam logic [7:0] KB_RESEND   = 8'hFE;
    localparam logic [7:0] KB_NULL     = 8'h00;
    localparam logic [7:0] KB_ERR      = 8'hFF;

    localparam logic [8:0] PAUSE_CODE = 9'h177;
    // Pause is E1 followed by seven more bytes that carry no key information.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFIX,
        ST_SKIP_E1
    } kbd_state_e;

    typedef struct packed {
        logic       brk;
        logic [8:0] code;
    } kbd_evt_t;

    // Protocol chatter that never forms a key event and leaves prefixes alone.
    function automatic logic is_filler(input logic [7:0] b);
        return (b == KB_ACK) || (b == KB_ECHO) || (b == KB_RESEND) ||
               (b == KB_NULL) || (b == KB_ERR);
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO without a
// simultaneous pop is dropped and flagged on drop_o for one cycle.
module kbd_event_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  kbd_evt_t                 din_i,
    input  logic                     pop_i,
    output kbd_evt_t                 dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);

    localparam int AW = $clog2(DEPTH);

    kbd_evt_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && !push_ok;
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// Set-2 scan byte parser that tracks held keys and queues make/break events
// for a consumer that polls through a valid/ready pop handshake.
module ps2_key_event_queue
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter bit FILTER_REPEAT = 1'b1,
    parameter bit REQUIRE_BAT   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    output logic [511:0]                  key_down,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [8:0]                    evt_code,
    output logic                          evt_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic                          kbd_ready
);

    kbd_state_e    state_q, state_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [2:0]    skip_q, skip_d;
    logic [511:0]  key_down_q, key_down_d;
    logic          kbd_ready_q, kbd_ready_d;
    logic          overflow_q, overflow_d;

    logic          accept, idle_s, evt_byte_s;
    logic          gen, is_pause, bat_ok, bat_fail;
    kbd_evt_t      gen_evt, head_evt;
    logic          drop_rep, push, fifo_drop, fifo_empty, fifo_full;

    // Before BAT completes only AA can get through.
    assign accept = byte_valid && (kbd_ready_q || byte_in == KB_BAT_OK);
    assign idle_s = (state_q == ST_IDLE);
    assign evt_byte_s = !(byte_in == KB_EXT || byte_in == KB_BRK || is_filler(byte_in)) &&
                        !(idle_s && (byte_in == KB_PAUSE || byte_in == KB_BAT_OK ||
                                     byte_in == KB_BAT_FAIL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            skip_q      <= '0;
            key_down_q  <= '0;
            kbd_ready_q <= !REQUIRE_BAT;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            skip_q      <= skip_d;
            key_down_q  <= key_down_d;
            kbd_ready_q <= kbd_ready_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        skip_d  = skip_q;
        if (accept) begin
            case (state_q)
                ST_SKIP_E1: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = ST_IDLE;
                end
                default: begin
                    if (byte_in == KB_EXT) begin
                        ext_d   = 1'b1;
                        state_d = ST_PREFIX;
                    end else if (byte_in == KB_BRK) begin
                        brk_d   = 1'b1;
                        state_d = ST_PREFIX;
                    end else if (idle_s && byte_in == KB_PAUSE) begin
                        skip_d  = PAUSE_SKIP;
                        state_d = ST_SKIP_E1;
                    end else if (evt_byte_s) begin
                        ext_d   = 1'b0;
                        brk_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        gen      = 1'b0;
        gen_evt  = '0;
        is_pause = 1'b0;
        bat_ok   = 1'b0;
        bat_fail = 1'b0;
        if (accept) begin
            case (state_q)
                ST_SKIP_E1: begin
                    if (skip_q == 3'd1) begin
                        gen          = 1'b1;
                        is_pause     = 1'b1;
                        gen_evt.code = PAUSE_CODE;
                    end
                end
                default: begin
                    if (idle_s && byte_in == KB_BAT_OK) begin
                        bat_ok = 1'b1;
                    end else if (idle_s && byte_in == KB_BAT_FAIL) begin
                        bat_fail = 1'b1;
                    end else if (evt_byte_s) begin
                        gen     = 1'b1;
                        gen_evt = '{brk: brk_q, code: {ext_q, byte_in}};
                    end
                end
            endcase
        end
    end

    // Typematic repeats of a held key are swallowed before they reach the FIFO.
    assign drop_rep = FILTER_REPEAT && !gen_evt.brk && key_down_q[gen_evt.code];
    assign push     = gen && !drop_rep;

    always_comb begin
        key_down_d = key_down_q;
        if (bat_ok)
            key_down_d = '0;
        else if (push && !is_pause)
            key_down_d[gen_evt.code] = !gen_evt.brk;
    end

    always_comb begin
        kbd_ready_d = kbd_ready_q;
        if (bat_ok)        kbd_ready_d = 1'b1;
        else if (bat_fail) kbd_ready_d = 1'b0;
    end

    // A fresh drop wins over a simultaneous clear.
    assign overflow_d = (overflow_q && !clr_overflow) || fifo_drop;

    kbd_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (gen_evt),
        .pop_i   (evt_ready),
        .dout_o  (head_evt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = head_evt.code;
    assign evt_break = head_evt.brk;
    assign key_down  = key_down_q;
    assign kbd_ready = kbd_ready_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Bench for ps2_key_event_queue: directed vector table, corner sequences and a
// randomized run checked against a queue-based behavioural model.
module tb_ps2_key_event_queue;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   byte_in = 8'h00;
    logic         byte_valid = 1'b0;
    logic         evt_ready = 1'b0;
    logic         clr_overflow = 1'b0;

    logic [511:0] key_down, b_key_down;
    logic         evt_valid, b_evt_valid;
    logic [8:0]   evt_code, b_evt_code;
    logic         evt_break, b_evt_break;
    logic [3:0]   fifo_count, b_fifo_count;
    logic         overflow, b_overflow;
    logic         kbd_ready, b_kbd_ready;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ps2_key_event_queue #(.FIFO_DEPTH(8), .FILTER_REPEAT(1'b1), .REQUIRE_BAT(1'b1)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .key_down(key_down), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_break(evt_break), .fifo_count(fifo_count),
        .overflow(overflow), .clr_overflow(clr_overflow), .kbd_ready(kbd_ready)
    );

    // Second instance: repeats queued, no BAT gate.
    ps2_key_event_queue #(.FIFO_DEPTH(8), .FILTER_REPEAT(1'b0), .REQUIRE_BAT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .key_down(b_key_down), .evt_valid(b_evt_valid), .evt_ready(evt_ready),
        .evt_code(b_evt_code), .evt_break(b_evt_break), .fifo_count(b_fifo_count),
        .overflow(b_overflow), .clr_overflow(clr_overflow), .kbd_ready(b_kbd_ready)
    );

    // ---------------- reference model (instance dut) ----------------
    logic [9:0]   m_q[$];        // {brk, code}
    bit   [511:0] m_down;
    bit           m_ready, m_ovf, m_ext, m_brk;
    int           m_skip;

    function automatic void m_reset();
        m_q.delete();
        m_down = '0; m_ready = 0; m_ovf = 0; m_ext = 0; m_brk = 0; m_skip = 0;
    endfunction

    function automatic void m_step(input bit bv, input bit [7:0] b, input bit rdy, input bit clr);
        bit have = 0, brk = 0, pause = 0, drop = 0, popping, idle;
        bit [8:0] code = '0;
        popping = rdy && (m_q.size() > 0);
        if (bv && (m_ready || b == 8'hAA)) begin
            if (m_skip > 0) begin
                m_skip--;
                if (m_skip == 0) begin have = 1; code = 9'h177; pause = 1; end
            end else begin
                idle = !m_ext && !m_brk;
                if (b == 8'hE0) m_ext = 1;
                else if (b == 8'hF0) m_brk = 1;
                else if (idle && b == 8'hE1) m_skip = 7;
                else if (idle && b == 8'hAA) begin m_ready = 1; m_down = '0; end
                else if (idle && b == 8'hFC) m_ready = 0;
                else if (b inside {8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) ;
                else begin
                    have = 1; code = {m_ext, b}; brk = m_brk; m_ext = 0; m_brk = 0;
                end
            end
        end
        if (have) begin
            if (!brk && m_down[code]) have = 0;
            else if (!pause) m_down[code] = !brk;
        end
        if (popping) void'(m_q.pop_front());
        if (have) begin
            if (m_q.size() < 8) m_q.push_back({brk, code});
            else drop = 1;
        end
        if (clr) m_ovf = 0;
        if (drop) m_ovf = 1;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_model();
        chk("m_valid", 512'(evt_valid), 512'(m_q.size() > 0));
        chk("m_count", 512'(fifo_count), 512'(m_q.size()));
        chk("m_ovf", 512'(overflow), 512'(m_ovf));
        chk("m_ready", 512'(kbd_ready), 512'(m_ready));
        chk("m_keydown", key_down, m_down);
        if (m_q.size() > 0) begin
            chk("m_code", 512'(evt_code), 512'(m_q[0][8:0]));
            chk("m_brk", 512'(evt_break), 512'(m_q[0][9]));
        end
    endtask

    task automatic cyc(input logic bv, input logic [7:0] b, input logic rdy, input logic clr);
        @(negedge clk);
        byte_valid = bv; byte_in = b; evt_ready = rdy; clr_overflow = clr;
        @(posedge clk);
        m_step(bv, b, rdy, clr);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        byte_valid = 0; evt_ready = 0; clr_overflow = 0; rst = 1;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       bv;
        logic [7:0] b;
        logic       rdy;
        logic       valid;
        logic [8:0] code;
        logic       brk;
        int         cnt;
        logic       ready;
        int         kd;
        logic       kdv;
    } vec_t;

    function automatic vec_t mk(logic bv, logic [7:0] b, logic rdy, logic valid,
                                logic [8:0] code, logic brk, int cnt, logic ready,
                                int kd, logic kdv);
        vec_t v;
        v.bv = bv; v.b = b; v.rdy = rdy; v.valid = valid; v.code = code;
        v.brk = brk; v.cnt = cnt; v.ready = ready; v.kd = kd; v.kdv = kdv;
        return v;
    endfunction

    vec_t tbl[11];

    initial begin
        tbl[0]  = mk(1, 8'h1C, 0, 0, 9'h000, 0, 0, 0,  28, 0);
        tbl[1]  = mk(1, 8'hAA, 0, 0, 9'h000, 0, 0, 1,  28, 0);
        tbl[2]  = mk(1, 8'h1C, 0, 1, 9'h01C, 0, 1, 1,  28, 1);
        tbl[3]  = mk(1, 8'hE0, 0, 1, 9'h01C, 0, 1, 1, 373, 0);
        tbl[4]  = mk(1, 8'h75, 0, 1, 9'h01C, 0, 2, 1, 373, 1);
        tbl[5]  = mk(1, 8'hE0, 0, 1, 9'h01C, 0, 2, 1, 373, 1);
        tbl[6]  = mk(1, 8'hF0, 0, 1, 9'h01C, 0, 2, 1, 373, 1);
        tbl[7]  = mk(1, 8'h75, 0, 1, 9'h01C, 0, 3, 1, 373, 0);
        tbl[8]  = mk(0, 8'h00, 1, 1, 9'h175, 0, 2, 1, 373, 0);
        tbl[9]  = mk(0, 8'h00, 1, 1, 9'h175, 1, 1, 1, 373, 0);
        tbl[10] = mk(0, 8'h00, 1, 0, 9'h000, 0, 0, 1,  28, 1);

        m_reset();
        do_reset();

        // reset state
        chk("rst_keydown", key_down, '0);
        chk("rst_valid", 512'(evt_valid), 512'(0));
        chk("rst_code", 512'(evt_code), 512'(0));
        chk("rst_break", 512'(evt_break), 512'(0));
        chk("rst_count", 512'(fifo_count), 512'(0));
        chk("rst_ovf", 512'(overflow), 512'(0));
        chk("rst_ready", 512'(kbd_ready), 512'(0));
        chk("rst_ready_nobat", 512'(b_kbd_ready), 512'(1));

        // BAT gating, E0 make/break and FWFT pops
        foreach (tbl[i]) begin
            cyc(tbl[i].bv, tbl[i].b, tbl[i].rdy, 1'b0);
            chk($sformatf("tbl%0d_valid", i), 512'(evt_valid), 512'(tbl[i].valid));
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d_code", i), 512'(evt_code), 512'(tbl[i].code));
                chk($sformatf("tbl%0d_brk", i), 512'(evt_break), 512'(tbl[i].brk));
            end
            chk($sformatf("tbl%0d_count", i), 512'(fifo_count), 512'(tbl[i].cnt));
            chk($sformatf("tbl%0d_ready", i), 512'(kbd_ready), 512'(tbl[i].ready));
            chk($sformatf("tbl%0d_kd", i), 512'(key_down[tbl[i].kd]), 512'(tbl[i].kdv));
            check_model();
        end

        // typematic filtering: filtered instance sees make+break, unfiltered all four
        do_reset();
        send(8'hAA);
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        idle();
        chk("filter_count", 512'(fifo_count), 512'(2));
        chk("nofilter_count", 512'(b_fifo_count), 512'(4));
        check_model();
        cyc(0, 8'h00, 1, 0);
        chk("filter_second_brk", 512'(evt_break), 512'(1));
        check_model();

        // Pause sequence
        do_reset();
        send(8'hAA);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        idle();
        chk("pause_count", 512'(fifo_count), 512'(1));
        chk("pause_code", 512'(evt_code), 512'(9'h177));
        chk("pause_brk", 512'(evt_break), 512'(0));
        chk("pause_keydown", key_down, '0);
        check_model();

        // overflow with nine distinct makes, then drain in order
        do_reset();
        send(8'hAA);
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
        idle();
        chk("ovf_count", 512'(fifo_count), 512'(8));
        chk("ovf_flag", 512'(overflow), 512'(1));
        chk("ovf_9th_kd", 512'(key_down[9'h018]), 512'(1));
        check_model();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_code", i), 512'(evt_code), 512'(9'h010 + 9'(i)));
            cyc(0, 8'h00, 1, 0);
        end
        chk("drain_empty", 512'(evt_valid), 512'(0));
        cyc(0, 8'h00, 0, 1);
        chk("ovf_cleared", 512'(overflow), 512'(0));
        check_model();

        // push and pop together on a full FIFO; clear racing a new drop
        do_reset();
        send(8'hAA);
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
        cyc(1, 8'h28, 1, 0);
        chk("full_pp_count", 512'(fifo_count), 512'(8));
        chk("full_pp_ovf", 512'(overflow), 512'(0));
        chk("full_pp_head", 512'(evt_code), 512'(9'h021));
        cyc(1, 8'h29, 0, 1);
        chk("clr_vs_drop_ovf", 512'(overflow), 512'(1));
        check_model();

        // reset after a partial prefix leaves no trace
        do_reset();
        send(8'hAA); send(8'hE0); send(8'hF0);
        do_reset();
        send(8'hAA); send(8'h1C); idle();
        chk("midrst_code", 512'(evt_code), 512'(9'h01C));
        chk("midrst_brk", 512'(evt_break), 512'(0));
        check_model();

        // randomized run against the model
        do_reset();
        send(8'hAA);
        for (int n = 0; n < 2500; n++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 19));
            case (r)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                5:       b = 8'hAA;
                6:       b = 8'hFC;
                7:       b = ($urandom_range(0, 1) == 0) ? 8'hFA : 8'h00;
                default: b = 8'h10 + 8'($urandom_range(0, 7));
            endcase
            cyc(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 15) == 0));
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
